div_seq: RTL and testbench

Sequential restoring divider. It is the inverse companion of the shift-add multiplier in the arithmetic cores.
- On an `init` pulse it captures an unsigned dividend and divisor.
- It produces one quotient bit per clock, then raises `done` for one cycle with quotient and remainder valid.
- It uses the same `init`/`done` handshake as the multiplier, so the same top-level or processor peripheral wrapper can drive both.

---
 rtl/div_seq.sv | 130 +++++++++++++
 tb/tb_div_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per clock.
// Shares the init/done handshake of the shift-add multiplier.
module div_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] d_r;
  logic [CW-1:0]    cnt;
  logic             dz_r;

  logic             start;
  logic             last;
  logic [WIDTH:0]   trial;
  logic             borrow;

  // Load only from IDLE; the final iteration is the one with cnt at 1.
  assign start = (state == IDLE) && init;
  assign last  = (state == CALC) && (cnt == CW'(1));

  // Trial subtraction of the divisor from the shifted partial remainder.
  // The partial remainder stays below the divisor, so bit WIDTH is the borrow.
  assign trial  = {r_r, q_r[WIDTH-1]} - {1'b0, d_r};
  assign borrow = trial[WIDTH];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (init) state_nx = CALC;
      CALC: if (last) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        done = 1'b0;
      end
      CALC: begin
        busy = 1'b1;
        done = 1'b0;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath: load operands, then shift-subtract once per CALC cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r <= '0;
      r_r <= '0;
      d_r <= '0;
      cnt <= '0;
    end else if (start) begin
      q_r <= A;
      r_r <= '0;
      d_r <= B;
      cnt <= CW'(WIDTH);
    end else if (state == CALC) begin
      cnt <= cnt - CW'(1);
      if (!borrow) begin
        r_r <= trial[WIDTH-1:0];
        q_r <= {q_r[WIDTH-2:0], 1'b1};
      end else begin
        r_r <= {r_r[WIDTH-2:0], q_r[WIDTH-1]};
        q_r <= {q_r[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Divide-by-zero flag, held with its result until the next load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dz_r <= 1'b0;
    end else if (start) begin
      dz_r <= (B == '0);
    end
  end

  assign Q  = q_r;
  assign R  = r_r;
  assign dz = dz_r;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq.
// Random and directed operands against an arithmetic reference model.
module tb_div_seq;

  localparam int W = 8;
  localparam int TO = 40;

  logic         clk;
  logic         rst;
  logic         init;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         busy;
  logic         done;
  logic         dz;

  int checks;
  int failures;

  div_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .init(init),
    .A   (A),
    .B   (B),
    .Q   (Q),
    .R   (R),
    .busy(busy),
    .done(done),
    .dz  (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_q(input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    if (b == 0) return {W{1'b1}};
    return a / b;
  endfunction

  function automatic logic [W-1:0] ref_r(input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    if (b == 0) return a;
    return a % b;
  endfunction

  // Drive one op at a negedge, wait for done, check latency/result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input string name);
    int n;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    eq = ref_q(a, b);
    er = ref_r(a, b);
    @(negedge clk);
    A = a;
    B = b;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    n = 0;
    while (!done && n < TO) begin
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL %s busy_calc: got %b want 1", name, busy);
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== W) begin
      failures++;
      $display("FAIL %s latency: got %0d want %0d", name, n, W);
    end
    checks++;
    if (Q !== eq || R !== er || dz !== (b == 0) || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s result: got Q=%0d R=%0d dz=%b busy=%b want Q=%0d R=%0d dz=%b busy=1",
               name, Q, R, dz, busy, eq, er, (b == 0));
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || Q !== eq || R !== er) begin
      failures++;
      $display("FAIL %s after_done: got done=%b busy=%b Q=%0d R=%0d want 0 0 %0d %0d",
               name, done, busy, Q, R, eq, er);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    init = 1'b0;
    A = '0;
    B = '0;
    #1;
    checks++;
    if (Q !== 0 || R !== 0 || done !== 0 || busy !== 0 || dz !== 0) begin
      failures++;
      $display("FAIL reset: got Q=%0d R=%0d done=%b busy=%b dz=%b want all 0",
               Q, R, done, busy, dz);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed();
    run_op(8'd100, 8'd7, "d100_7");
    run_op(8'd255, 8'd1, "d255_1");
    run_op(8'd5, 8'd9, "d5_9");
    run_op(8'd0, 8'd3, "d0_3");
  endtask

  task automatic test_div_zero();
    run_op(8'd200, 8'd0, "dz200_0");
    run_op(8'd9, 8'd3, "d9_3");
    run_op(8'd0, 8'd0, "dz0_0");
    run_op(8'd255, 8'd255, "d255_255");
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = (i % 8 == 0) ? '0 : W'($urandom_range(1, 255));
      run_op(a, b, "rand");
    end
  endtask

  task automatic test_init_held();
    int pulses;
    logic prev;
    @(negedge clk);
    A = 8'd50;
    B = 8'd6;
    init = 1'b1;
    pulses = 0;
    prev = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        checks++;
        if (Q !== 8'd8 || R !== 8'd2 || prev) begin
          failures++;
          $display("FAIL held_result: got Q=%0d R=%0d prev_done=%b want 8 2 0",
                   Q, R, prev);
        end
        checks++;
        if (i % (W + 2) !== W) begin
          failures++;
          $display("FAIL held_timing: done after edge %0d want %0d mod %0d",
                   i, W, W + 2);
        end
      end
      prev = done;
    end
    init = 1'b0;
    checks++;
    if (pulses !== 3) begin
      failures++;
      $display("FAIL held_pulses: got %0d want 3", pulses);
    end
    repeat (W + 3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    A = 8'd100;
    B = 8'd7;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (Q !== 0 || R !== 0 || done !== 0 || busy !== 0 || dz !== 0) begin
      failures++;
      $display("FAIL rst_mid: got Q=%0d R=%0d done=%b busy=%b dz=%b want all 0",
               Q, R, done, busy, dz);
    end
    seen = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL rst_mid_quiet: got %0d active cycles want 0", seen);
    end
    run_op(8'd100, 8'd7, "post_rst");
  endtask

  task automatic test_operand_change();
    int n;
    int pulses;
    logic [W-1:0] a;
    logic [W-1:0] b;
    a = W'($urandom);
    b = W'($urandom_range(1, 255));
    @(negedge clk);
    A = a;
    B = b;
    init = 1'b1;
    @(negedge clk);
    n = 0;
    while (!done && n < TO) begin
      A = W'($urandom);
      B = W'($urandom);
      init = n[0];
      @(negedge clk);
      n++;
    end
    init = 1'b1;
    checks++;
    if (!done || Q !== ref_q(a, b) || R !== ref_r(a, b)) begin
      failures++;
      $display("FAIL chg_result: got done=%b Q=%0d R=%0d want 1 %0d %0d",
               done, Q, R, ref_q(a, b), ref_r(a, b));
    end
    @(negedge clk);
    init = 1'b0;
    pulses = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    checks++;
    if (pulses !== 0 || Q !== ref_q(a, b) || R !== ref_r(a, b)) begin
      failures++;
      $display("FAIL chg_no_extra: got active=%0d Q=%0d R=%0d want 0 %0d %0d",
               pulses, Q, R, ref_q(a, b), ref_r(a, b));
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_div_zero();
    test_random();
    test_init_held();
    test_reset_mid();
    test_operand_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
